// File: rtl/sm_fv_pingpong_bank_if.sv
// Stream-capture and line-read bundle for the ping-pong FV bank.
// The master side is the upstream streamer plus the compute-side reader; the slave side is the bank.
interface sm_fv_pingpong_bank_if #(
  parameter int FV_BW  = 32,
  parameter int ADDR_W = 6
);
  logic              strm_valid;
  logic              strm_sos;
  logic              strm_eos;
  logic [ADDR_W-1:0] strm_addr;
  logic [FV_BW-1:0]  strm_data;
  logic              strm_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [FV_BW-1:0]  rd_data;
  logic              rd_buf_ready;
  logic              rd_done;
  logic              fill_buf_id;
  logic              rd_buf_id;
  logic [ADDR_W:0]   line_cnt;
  logic              proto_err;

  modport master (
    output strm_valid, strm_sos, strm_eos, strm_addr, strm_data,
    output rd_req, rd_addr, rd_done,
    input  strm_ready, rd_valid, rd_data, rd_buf_ready,
    input  fill_buf_id, rd_buf_id, line_cnt, proto_err
  );

  modport slave (
    input  strm_valid, strm_sos, strm_eos, strm_addr, strm_data,
    input  rd_req, rd_addr, rd_done,
    output strm_ready, rd_valid, rd_data, rd_buf_ready,
    output fill_buf_id, rd_buf_id, line_cnt, proto_err
  );
endinterface

// File: rtl/sm_fv_pingpong_bank.sv
// Two-buffer FV line bank: one buffer captures an sos/eos framed stream while the other serves
// single-cycle-latency reads. Each buffer walks EMPTY -> FILL -> FULL -> EMPTY.
//
// state    | meaning
// ST_EMPTY | free; waits for an sos beat
// ST_FILL  | capturing stream beats
// ST_FULL  | eos seen; readable until rd_done
module sm_fv_pingpong_bank #(
  parameter int FV_BW  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input logic                  clk,
  input logic                  reset,
  sm_fv_pingpong_bank_if.slave bus
);
  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL} buf_st_t;

  buf_st_t           r_st [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic              r_rd_valid;
  logic [FV_BW-1:0]  r_rd_data;
  logic [ADDR_W:0]   r_line_cnt;
  logic              r_proto_err;
  logic [FV_BW-1:0]  r_mem [2][DEPTH];

  logic w_ready, w_acc, w_drop, w_restart, w_wr, w_rd_ok, w_release;

  assign w_ready   = (r_st[r_wr_ptr] != ST_FULL);
  assign w_acc     = bus.strm_valid && w_ready;
  assign w_drop    = w_acc && !bus.strm_sos && (r_st[r_wr_ptr] == ST_EMPTY);
  assign w_restart = w_acc && bus.strm_sos && (r_st[r_wr_ptr] == ST_FILL);
  assign w_wr      = w_acc && !w_drop;
  assign w_rd_ok   = (r_st[r_rd_ptr] == ST_FULL);
  assign w_release = bus.rd_done && w_rd_ok;

  // Fill and release never target the same buffer: fill needs EMPTY/FILL, release needs FULL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st[0]     <= ST_EMPTY;
      r_st[1]     <= ST_EMPTY;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_line_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_wr && (r_wr_ptr == 1'(i)))
          r_st[i] <= bus.strm_eos ? ST_FULL : ST_FILL;
        else if (w_release && (r_rd_ptr == 1'(i)))
          r_st[i] <= ST_EMPTY;
      end
      if (w_wr && bus.strm_eos)
        r_wr_ptr <= ~r_wr_ptr;
      if (w_release)
        r_rd_ptr <= ~r_rd_ptr;

      if (w_wr) begin
        if (bus.strm_sos)
          r_line_cnt <= (ADDR_W+1)'(1);
        else if (r_line_cnt < (ADDR_W+1)'(DEPTH))
          r_line_cnt <= r_line_cnt + 1'b1;
      end
      if (w_drop || w_restart)
        r_proto_err <= 1'b1;

      if (bus.rd_req && w_rd_ok) begin
        r_rd_data  <= r_mem[r_rd_ptr][bus.rd_addr];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Line storage carries no reset so it can map onto plain register/RAM cells.
  always_ff @(posedge clk) begin
    if (!reset && w_wr)
      r_mem[r_wr_ptr][bus.strm_addr] <= bus.strm_data;
  end

  assign bus.strm_ready   = w_ready;
  assign bus.rd_buf_ready = w_rd_ok;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.fill_buf_id  = r_wr_ptr;
  assign bus.rd_buf_id    = r_rd_ptr;
  assign bus.line_cnt     = r_line_cnt;
  assign bus.proto_err    = r_proto_err;
endmodule
